// File: rtl/fifo_sync_flags_if.sv
// Producer/consumer handshake bundle for fifo_sync_flags.
// The master side drives requests and write data; the slave (the FIFO) returns data and status.
interface fifo_sync_flags_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                  wr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr, wr_data, rd,
        input  rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr, wr_data, rd,
        output rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with owned storage, occupancy counter, programmable almost flags
// and one-cycle overflow/underflow pulses. Registered (non-FWFT) read data.
module fifo_sync_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 1,
    parameter int AE_THRESH  = 1
) (
    input logic              clk,
    input logic              reset_n,
    fifo_sync_flags_if.slave bus
);
    localparam int                  DEPTH   = 1 << ADDR_WIDTH;
    localparam int                  CW      = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = CW'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = CW'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_C    = CW'(AE_THRESH);
    localparam logic                AF_RST  = (AF_THRESH == 0);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   count_nxt;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  full_q;
    logic                  empty_q;
    logic                  af_q;
    logic                  ae_q;
    logic                  ovf_q;
    logic                  unf_q;
    logic                  rd_acc;
    logic                  wr_acc;

    // A read frees a slot in the same edge, so a full FIFO still takes a paired write.
    assign rd_acc = bus.rd & ~empty_q;
    assign wr_acc = bus.wr & (~full_q | rd_acc);

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        count_nxt = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count_q + CW'(1);
            2'b01:   count_nxt = count_q - CW'(1);
            default: count_nxt = count_q;
        endcase
    end

    // NOTE: the storage array has no reset; only pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            af_q      <= AF_RST;
            ae_q      <= 1'b1;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_acc) begin
                rd_ptr    <= rd_ptr + ADDR_WIDTH'(1);
                rd_data_q <= mem[rd_ptr];
            end
            count_q <= count_nxt;
            // Flags come from the next count so they move on the same edge as count.
            full_q  <= (count_nxt == DEPTH_C);
            empty_q <= (count_nxt == '0);
            af_q    <= (count_nxt >= AF_C);
            ae_q    <= (count_nxt <= AE_C);
            ovf_q   <= bus.wr & ~wr_acc;
            unf_q   <= bus.rd & ~rd_acc;
        end
    end

    assign bus.rd_data      = rd_data_q;
    assign bus.count        = count_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed bench for fifo_sync_flags (8x8, AF=6, AE=1) with hand-computed expectations.
module tb_fifo_sync_flags;
    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    fifo_sync_flags_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

    fifo_sync_flags #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(3),
        .AF_THRESH (6),
        .AE_THRESH (1)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string tag, input int cnt);
        check({tag, " count"}, 32'(bus.count), 32'(cnt));
        check({tag, " full"}, 32'(bus.full), 32'(cnt == 8));
        check({tag, " empty"}, 32'(bus.empty), 32'(cnt == 0));
        check({tag, " almost_full"}, 32'(bus.almost_full), 32'(cnt >= 6));
        check({tag, " almost_empty"}, 32'(bus.almost_empty), 32'(cnt <= 1));
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset_n      = 1'b0;
        bus.wr       = 1'b0;
        bus.rd       = 1'b0;
        bus.wr_data  = '0;

        // Reset state
        repeat (2) tick();
        check_flags("reset", 0);
        check("reset rd_data", 32'(bus.rd_data), 32'h0);
        check("reset overflow", 32'(bus.overflow), 32'h0);
        check("reset underflow", 32'(bus.underflow), 32'h0);
        reset_n = 1'b1;

        // Fill 0x10..0x17
        for (int i = 0; i < 8; i++) begin
            bus.wr      = 1'b1;
            bus.wr_data = 8'(8'h10 + i);
            tick();
            check_flags($sformatf("fill%0d", i), i + 1);
            check($sformatf("fill%0d overflow", i), 32'(bus.overflow), 32'h0);
        end

        // Overflow from full
        bus.wr_data = 8'hAA;
        tick();
        bus.wr = 1'b0;
        check("ovf pulse", 32'(bus.overflow), 32'h1);
        check_flags("ovf", 8);
        tick();
        check("ovf cleared", 32'(bus.overflow), 32'h0);
        check_flags("ovf after", 8);

        // Drain: must return 0x10..0x17, never 0xAA
        for (int i = 0; i < 8; i++) begin
            bus.rd = 1'b1;
            tick();
            check($sformatf("drain%0d rd_data", i), 32'(bus.rd_data), 32'(8'h10 + i));
            check_flags($sformatf("drain%0d", i), 7 - i);
            check($sformatf("drain%0d underflow", i), 32'(bus.underflow), 32'h0);
        end
        bus.rd = 1'b0;

        // Underflow on empty
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
        check("unf pulse", 32'(bus.underflow), 32'h1);
        check("unf rd_data held", 32'(bus.rd_data), 32'h17);
        check_flags("unf", 0);
        tick();
        check("unf cleared", 32'(bus.underflow), 32'h0);

        // Simultaneous on empty: write only
        bus.wr      = 1'b1;
        bus.rd      = 1'b1;
        bus.wr_data = 8'h55;
        tick();
        bus.rd = 1'b0;
        check("sim_empty underflow", 32'(bus.underflow), 32'h1);
        check("sim_empty rd_data", 32'(bus.rd_data), 32'h17);
        check_flags("sim_empty", 1);

        // Top up with 0x20..0x26 to reach full
        for (int i = 0; i < 7; i++) begin
            bus.wr_data = 8'(8'h20 + i);
            tick();
            check_flags($sformatf("topup%0d", i), i + 2);
        end

        // Simultaneous on full: both accepted
        bus.rd      = 1'b1;
        bus.wr_data = 8'h66;
        tick();
        bus.wr = 1'b0;
        check("sim_full overflow", 32'(bus.overflow), 32'h0);
        check("sim_full rd_data", 32'(bus.rd_data), 32'h55);
        check_flags("sim_full", 8);

        // Read five words down to count 3; FIFO then holds 0x25, 0x26, 0x66
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("trim%0d rd_data", i), 32'(bus.rd_data), 32'(8'h20 + i));
            check_flags($sformatf("trim%0d", i), 7 - i);
        end

        // Wrap-around: 20 concurrent cycles at count 3
        bus.wr = 1'b1;
        for (int i = 0; i < 20; i++) begin
            logic [7:0] exp_d;
            bus.wr_data = 8'(8'h80 + i);
            tick();
            if (i == 0)      exp_d = 8'h25;
            else if (i == 1) exp_d = 8'h26;
            else if (i == 2) exp_d = 8'h66;
            else             exp_d = 8'(8'h80 + i - 3);
            check($sformatf("wrap%0d rd_data", i), 32'(bus.rd_data), 32'(exp_d));
            check_flags($sformatf("wrap%0d", i), 3);
        end
        bus.rd = 1'b0;

        // Grow to count 5, then reset between edges
        bus.wr_data = 8'hA0;
        tick();
        bus.wr_data = 8'hA1;
        tick();
        bus.wr = 1'b0;
        check_flags("pre_reset", 5);
        #2;
        reset_n = 1'b0;
        #1;
        check_flags("mid_reset", 0);
        check("mid_reset rd_data", 32'(bus.rd_data), 32'h0);
        tick();
        reset_n = 1'b1;

        // Fresh write then read after reset
        bus.wr      = 1'b1;
        bus.wr_data = 8'h3C;
        tick();
        bus.wr = 1'b0;
        check_flags("post_reset wr", 1);
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
        check("post_reset rd_data", 32'(bus.rd_data), 32'h3C);
        check_flags("post_reset rd", 0);
        check("post_reset underflow", 32'(bus.underflow), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
